img_mem_reader_scaled: RTL and testbench
========================================

Name: img_mem_reader_scaled

Overview:
- Parametrised, pipelined successor to the combinational frame-buffer reader in the VGA display path.
- Maps VGA raster coordinates onto a stored source image placed at a programmable window offset, with optional 2x upscale.
- Issues registered addresses and read enables to a synchronous-read BRAM of configurable latency.
- Returns aligned 12-bit RGB plus a delayed DE, filling everything outside the window with a border colour.

Parameters:
- IMG_W, 320, source image width in pixels
- IMG_H, 240, source image height in pixels
- MEM_LAT, 1, BRAM read latency in clocks (1..3)
- ADDR_W, $clog2(IMG_W*IMG_H), address width
- BORDER_RGB, 12'h000, {r,g,b} colour for DE-active pixels outside the window

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  synchronous active-low reset
- DE  in  1  display enable from the VGA timing generator
- x_pixel  in  10  raster column
- y_pixel  in  10  raster row
- upscale  in  1  0: 1x, 1: 2x (each source pixel shown as 2x2)
- x_off  in  10  window left edge in raster coordinates
- y_off  in  10  window top edge in raster coordinates
- addr  out  ADDR_W  BRAM read address
- rd_en  out  1  BRAM read enable
- imgData  in  16  RGB565 read data, valid MEM_LAT clocks after the rd_en cycle
- r_port  out  4  red
- g_port  out  4  green
- b_port  out  4  blue
- de_out  out  1  DE delayed to align with RGB

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - addr, rd_en, de_out and RGB all 0.
  - Latched configuration cleared: upscale=0, offsets=0.
  - Delay pipelines flushed to 0.
  - Reset asserted mid-frame takes effect on the next edge; output restarts cleanly on the following pixels.
- Config latch:
  - upscale, x_off and y_off are sampled into shadow registers only on the cycle where x_pixel==0 && y_pixel==0.
  - Mid-frame changes to these inputs have no effect until the next frame start.
- Window, per cycle (combinational, using the shadow config):
  - s = shadow upscale.
  - xr = x_pixel - x_off and yr = y_pixel - y_off, both 11-bit, no wrap.
  - win = DE && x_pixel>=x_off && y_pixel>=y_off && (xr>>s)<IMG_W && (yr>>s)<IMG_H.
- Stage A (one clock after the raster coordinate):
  - On win: rd_en<=1 and addr<=(yr>>s)*IMG_W+(xr>>s).
  - Otherwise rd_en<=0 and addr holds its previous value; addr is never high-Z.
  - Address arithmetic is done at ADDR_W+1 bits. The maximum value is IMG_W*IMG_H-1; no address at or beyond IMG_W*IMG_H is ever issued.
- Delay line: win and DE are shifted through a MEM_LAT+1 deep pipeline alongside the read.
- Stage B (output register), MEM_LAT+1 clocks after Stage A:
  - delayed win=1: {r,g,b}<={imgData[15:12], imgData[10:7], imgData[4:1]}.
  - delayed DE=1 and delayed win=0: {r,g,b}<=BORDER_RGB.
  - delayed DE=0: {r,g,b}<=0.
  - de_out<=delayed DE.
- Total latency: raster coordinate to RGB/de_out = MEM_LAT+2 clocks, constant, independent of mode and window position.
- Window clipping: x_off/y_off may place the window partly off-screen. Only the visible portion is read; there is no wrap to column 0.
- 2x mode: each source address is issued on 2 consecutive columns and 2 consecutive rows; row base advances every second raster line.
- Throughput: one pixel per clock, no back-pressure, no stalls.

Test Plan:
- Reset: hold reset_n=0 for 3 clocks with DE=1 and the raster inside the window -> addr=0, rd_en=0, RGB=0, de_out=0 on every edge.
- 1x, offsets 0, MEM_LAT=1, model memory returning imgData=addr[15:0]:
  - (x,y)=(5,2) -> addr=645 one clock later.
  - RGB equal to the bit-slice of 645 three clocks after the coordinate.
  - (x,y)=(319,239) -> addr=76799.
  - (320,0) -> rd_en=0, RGB=BORDER_RGB.
- 2x mode latched at frame start, offsets (100,50):
  - (101,51) and (100,50) both -> addr=0.
  - (102,52) -> addr=321.
  - (739,529) -> addr=76799.
  - (740,50) -> border colour.
- Mid-frame change of upscale from 0 to 1 at y=10 -> mapping stays 1x for the rest of the frame; 2x applies only after the next (0,0).
- Latency check with MEM_LAT=3 and DE pulsed high for one cycle -> de_out pulses exactly 5 clocks later; RGB black before and after the pulse.
- Off-screen clip, x_off=600 in 1x mode -> rd_en only for x in 600..639; max addr on row 0 is 39.

Source files
------------

// File: rtl/img_mem_reader_scaled.sv
// ---------------------------------------------------------------------------
// img_mem_reader_scaled
//
// Maps VGA raster coordinates onto a source image stored in a synchronous
// BRAM. The image sits at a programmable window offset and may be shown at
// 1x or 2x (each source pixel as a 2x2 block). Raster pixels outside the
// window are painted with BORDER_RGB while DE is high, and black while DE
// is low.
//
// Ports:
//   clk, reset_n       pixel clock, synchronous active-low reset
//   DE                 display enable from the timing generator
//   x_pixel, y_pixel   raster column / row
//   upscale            0: 1x, 1: 2x (latched at frame start)
//   x_off, y_off       window top-left corner in raster space (latched
//                      at frame start)
//   addr, rd_en        BRAM read address / read enable (registered)
//   imgData            RGB565 read data
//   r_port/g_port/b_port  4-bit RGB out
//   de_out             DE delayed to line up with the RGB outputs
//
// Memory interface: addr is qualified by rd_en in the same cycle. The BRAM
// returns imgData exactly MEM_LAT clocks after that cycle and never stalls.
// There is no back-pressure, so one pixel is accepted and one produced
// every clock.
//
// Latency from raster coordinate to RGB/de_out is MEM_LAT+2 clocks,
// independent of mode and window position.
// ---------------------------------------------------------------------------
module img_mem_reader_scaled #(
   parameter int          IMG_W      = 320,
   parameter int          IMG_H      = 240,
   parameter int          MEM_LAT    = 1,
   parameter int          ADDR_W     = $clog2(IMG_W*IMG_H),
   parameter logic [11:0] BORDER_RGB = 12'h000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              DE,
   input  logic [9:0]        x_pixel,
   input  logic [9:0]        y_pixel,
   input  logic              upscale,
   input  logic [9:0]        x_off,
   input  logic [9:0]        y_off,
   output logic [ADDR_W-1:0] addr,
   output logic              rd_en,
   input  logic [15:0]       imgData,
   output logic [3:0]        r_port,
   output logic [3:0]        g_port,
   output logic [3:0]        b_port,
   output logic              de_out
);

   localparam int          AW1     = ADDR_W + 1;
   localparam int          DL      = MEM_LAT + 1;
   localparam logic [10:0] IMG_W_L = 11'(IMG_W);
   localparam logic [10:0] IMG_H_L = 11'(IMG_H);

   // shadow configuration, updated only at raster (0,0)
   logic              ups_q, ups_d;
   logic [9:0]        x_off_q, x_off_d;
   logic [9:0]        y_off_q, y_off_d;

   // stage A
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_en_q, rd_en_d;

   // window / DE delay line; bit 0 is loaded alongside stage A
   logic [DL-1:0]     win_pipe_q, win_pipe_d;
   logic [DL-1:0]     de_pipe_q, de_pipe_d;

   // stage B
   logic [11:0]       rgb_q, rgb_d;
   logic              de_out_q, de_out_d;

   logic [10:0]       xr, yr, xs, ys;
   logic              win;
   logic [AW1-1:0]    addr_calc;

   always_comb begin
      ups_d   = ups_q;
      x_off_d = x_off_q;
      y_off_d = y_off_q;
      if (x_pixel == 10'd0 && y_pixel == 10'd0) begin
         ups_d   = upscale;
         x_off_d = x_off;
         y_off_d = y_off;
      end

      // xr/yr are only meaningful when the raster is at or past the offset;
      // the >= terms in win guard the wrapped case, so nothing wraps to col 0.
      xr = {1'b0, x_pixel} - {1'b0, x_off_q};
      yr = {1'b0, y_pixel} - {1'b0, y_off_q};
      xs = ups_q ? {1'b0, xr[10:1]} : xr;
      ys = ups_q ? {1'b0, yr[10:1]} : yr;

      win = DE && (x_pixel >= x_off_q) && (y_pixel >= y_off_q)
            && (xs < IMG_W_L) && (ys < IMG_H_L);

      // win bounds xs/ys, so the result never reaches IMG_W*IMG_H.
      addr_calc = AW1'(ys) * AW1'(IMG_W) + AW1'(xs);

      rd_en_d = win;
      addr_d  = win ? addr_calc[ADDR_W-1:0] : addr_q;

      win_pipe_d = {win_pipe_q[DL-2:0], win};
      de_pipe_d  = {de_pipe_q[DL-2:0], DE};

      de_out_d = de_pipe_q[DL-1];
      if (win_pipe_q[DL-1]) begin
         rgb_d = {imgData[15:12], imgData[10:7], imgData[4:1]};
      end else if (de_pipe_q[DL-1]) begin
         rgb_d = BORDER_RGB;
      end else begin
         rgb_d = 12'h000;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ups_q      <= 1'b0;
         x_off_q    <= '0;
         y_off_q    <= '0;
         addr_q     <= '0;
         rd_en_q    <= 1'b0;
         win_pipe_q <= '0;
         de_pipe_q  <= '0;
         rgb_q      <= '0;
         de_out_q   <= 1'b0;
      end else begin
         ups_q      <= ups_d;
         x_off_q    <= x_off_d;
         y_off_q    <= y_off_d;
         addr_q     <= addr_d;
         rd_en_q    <= rd_en_d;
         win_pipe_q <= win_pipe_d;
         de_pipe_q  <= de_pipe_d;
         rgb_q      <= rgb_d;
         de_out_q   <= de_out_d;
      end
   end

   assign addr   = addr_q;
   assign rd_en  = rd_en_q;
   assign r_port = rgb_q[11:8];
   assign g_port = rgb_q[7:4];
   assign b_port = rgb_q[3:0];
   assign de_out = de_out_q;

   // RGB565 LSBs are dropped on the way to 4-bit channels; the top bit of
   // addr_calc is always zero because win bounds the coordinates.
   logic unused_bits;
   assign unused_bits = &{1'b0, imgData[11], imgData[5], imgData[0], addr_calc[ADDR_W]};

endmodule

// File: tb/tb_img_mem_reader_scaled.sv
// ---------------------------------------------------------------------------
// Bench for img_mem_reader_scaled. Two instances share the raster inputs:
// dut1 with MEM_LAT=1 and dut3 with MEM_LAT=3. Each has its own BRAM model
// returning imgData = addr[15:0].
// ---------------------------------------------------------------------------
module tb_img_mem_reader_scaled;

  localparam logic [11:0] BORDER = 12'hA5C;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        de_in = 1'b0;
  logic [9:0]  x_pixel = '0;
  logic [9:0]  y_pixel = '0;
  logic        upscale = 1'b0;
  logic [9:0]  x_off = '0;
  logic [9:0]  y_off = '0;

  logic [16:0] addr1, addr3;
  logic        rd_en1, rd_en3;
  logic [15:0] img1, img3;
  logic [3:0]  r1, g1, b1, r3, g3, b3;
  logic        de_out1, de_out3;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  img_mem_reader_scaled #(.MEM_LAT(1), .BORDER_RGB(BORDER)) dut1 (
    .clk(clk), .reset_n(reset_n), .DE(de_in), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .upscale(upscale), .x_off(x_off), .y_off(y_off), .addr(addr1), .rd_en(rd_en1),
    .imgData(img1), .r_port(r1), .g_port(g1), .b_port(b1), .de_out(de_out1));

  img_mem_reader_scaled #(.MEM_LAT(3), .BORDER_RGB(BORDER)) dut3 (
    .clk(clk), .reset_n(reset_n), .DE(de_in), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .upscale(upscale), .x_off(x_off), .y_off(y_off), .addr(addr3), .rd_en(rd_en3),
    .imgData(img3), .r_port(r3), .g_port(g3), .b_port(b3), .de_out(de_out3));

  // ---------------- BRAM models ----------------
  logic [15:0] mem1_q;
  logic [15:0] mem3_q [3];
  always @(posedge clk) begin
    mem1_q    <= addr1[15:0];
    mem3_q[0] <= addr3[15:0];
    mem3_q[1] <= mem3_q[0];
    mem3_q[2] <= mem3_q[1];
  end
  assign img1 = mem1_q;
  assign img3 = mem3_q[2];

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        de;
    logic        win;
    logic [16:0] a;
  } ent_t;

  ent_t        hist[$];
  logic [16:0] exp_addr;
  logic        exp_rd;
  logic        m_ups;
  int          m_xo, m_yo;
  logic [30:0] exp1_v, exp3_v;
  logic [30:0] act1_v, act3_v;
  int          checks = 0;
  int          errors = 0;

  assign act1_v = {rd_en1, addr1, de_out1, r1, g1, b1};
  assign act3_v = {rd_en3, addr3, de_out3, r3, g3, b3};

  function automatic ent_t ref_map(input logic de, input int x, input int y);
    ent_t e;
    int   xs, ys;
    e = '0;
    e.de = de;
    if (de && x >= m_xo && y >= m_yo) begin
      xs = m_ups ? (x - m_xo) / 2 : (x - m_xo);
      ys = m_ups ? (y - m_yo) / 2 : (y - m_yo);
      if (xs < 320 && ys < 240) begin
        e.win = 1'b1;
        e.a   = 17'(ys * 320 + xs);
      end
    end
    return e;
  endfunction

  function automatic logic [11:0] rgb_of(input ent_t e);
    logic [16:0] a;
    a = e.a;
    if (e.win)     return {a[15:12], a[10:7], a[4:1]};
    else if (e.de) return BORDER;
    else           return 12'h000;
  endfunction

  // Drives one raster cycle, advances the model and waits until just after
  // the clock edge so outputs can be sampled.
  task automatic cycle(input logic rst, input logic de, input int x, input int y);
    ent_t e;
    reset_n = !rst;
    de_in   = de;
    x_pixel = 10'(x);
    y_pixel = 10'(y);
    if (rst) begin
      e = '0;
      for (int i = 0; i < hist.size(); i++) hist[i] = '0;
      exp_addr = '0;
      exp_rd   = 1'b0;
      m_ups = 1'b0; m_xo = 0; m_yo = 0;
    end else begin
      e = ref_map(de, x, y);
      exp_rd = e.win;
      if (e.win) exp_addr = e.a;
      if (x == 0 && y == 0) begin
        m_ups = upscale; m_xo = int'(x_off); m_yo = int'(y_off);
      end
    end
    hist.push_front(e);
    if (hist.size() > 8) void'(hist.pop_back());
    exp1_v = {exp_rd, exp_addr, hist[2].de, rgb_of(hist[2])};
    exp3_v = {exp_rd, exp_addr, hist[4].de, rgb_of(hist[4])};
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    upscale = 1'b0; x_off = '0; y_off = '0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 10 + i, 5);
      checks++;
      if ({addr1, rd_en1, r1, g1, b1, de_out1} !== '0) begin
        errors++;
        $display("FAIL reset_dut1 edge %0d act=%h req=0", i, {addr1, rd_en1, r1, g1, b1, de_out1});
      end
      checks++;
      if ({addr3, rd_en3, r3, g3, b3, de_out3} !== '0) begin
        errors++;
        $display("FAIL reset_dut3 edge %0d act=%h req=0", i, {addr3, rd_en3, r3, g3, b3, de_out3});
      end
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 20 + i, 7);
      checks++;
      if (act1_v !== exp1_v) begin errors++; $display("FAIL post_reset dut1 act=%h req=%h", act1_v, exp1_v); end
      checks++;
      if (act3_v !== exp3_v) begin errors++; $display("FAIL post_reset dut3 act=%h req=%h", act3_v, exp3_v); end
    end
  endtask

  task automatic test_map_1x();
    logic [16:0] a645;
    a645 = 17'd645;
    upscale = 1'b0; x_off = '0; y_off = '0;
    cycle(1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 5, 2);
    checks++;
    if (addr1 !== 17'd645 || rd_en1 !== 1'b1) begin
      errors++; $display("FAIL map1x_addr_5_2 act=%0d/%b req=645/1", addr1, rd_en1);
    end
    cycle(1'b0, 1'b0, 6, 2);
    cycle(1'b0, 1'b0, 7, 2);
    checks++;
    if ({r1, g1, b1} !== {a645[15:12], a645[10:7], a645[4:1]}) begin
      errors++; $display("FAIL map1x_rgb_645 act=%h req=%h", {r1, g1, b1}, {a645[15:12], a645[10:7], a645[4:1]});
    end
    cycle(1'b0, 1'b1, 319, 239);
    checks++;
    if (addr1 !== 17'd76799) begin errors++; $display("FAIL map1x_addr_max act=%0d req=76799", addr1); end
    cycle(1'b0, 1'b1, 320, 0);
    checks++;
    if (rd_en1 !== 1'b0) begin errors++; $display("FAIL map1x_rd_en_320 act=%b req=0", rd_en1); end
    cycle(1'b0, 1'b0, 321, 0);
    cycle(1'b0, 1'b0, 322, 0);
    checks++;
    if ({r1, g1, b1} !== BORDER || de_out1 !== 1'b1) begin
      errors++; $display("FAIL map1x_border act=%h/%b req=%h/1", {r1, g1, b1}, de_out1, BORDER);
    end
    checks++;
    if (act3_v !== exp3_v) begin errors++; $display("FAIL map1x dut3 act=%h req=%h", act3_v, exp3_v); end
  endtask

  task automatic test_map_2x();
    upscale = 1'b1; x_off = 10'd100; y_off = 10'd50;
    cycle(1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 101, 51);
    checks++;
    if (addr1 !== 17'd0 || rd_en1 !== 1'b1) begin errors++; $display("FAIL map2x_101_51 act=%0d/%b req=0/1", addr1, rd_en1); end
    cycle(1'b0, 1'b1, 100, 50);
    checks++;
    if (addr1 !== 17'd0 || rd_en1 !== 1'b1) begin errors++; $display("FAIL map2x_100_50 act=%0d/%b req=0/1", addr1, rd_en1); end
    cycle(1'b0, 1'b1, 102, 52);
    checks++;
    if (addr1 !== 17'd321) begin errors++; $display("FAIL map2x_102_52 act=%0d req=321", addr1); end
    cycle(1'b0, 1'b1, 739, 529);
    checks++;
    if (addr1 !== 17'd76799) begin errors++; $display("FAIL map2x_max act=%0d req=76799", addr1); end
    cycle(1'b0, 1'b1, 740, 50);
    checks++;
    if (rd_en1 !== 1'b0) begin errors++; $display("FAIL map2x_rd_en_740 act=%b req=0", rd_en1); end
    cycle(1'b0, 1'b0, 741, 50);
    cycle(1'b0, 1'b0, 742, 50);
    checks++;
    if ({r1, g1, b1} !== BORDER) begin errors++; $display("FAIL map2x_border act=%h req=%h", {r1, g1, b1}, BORDER); end
    checks++;
    if (act3_v !== exp3_v) begin errors++; $display("FAIL map2x dut3 act=%h req=%h", act3_v, exp3_v); end
  endtask

  task automatic test_midframe_config();
    upscale = 1'b0; x_off = '0; y_off = '0;
    cycle(1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 3, 10);
    upscale = 1'b1;
    cycle(1'b0, 1'b1, 8, 12);
    checks++;
    if (addr1 !== 17'd3848) begin errors++; $display("FAIL midframe_still_1x act=%0d req=3848", addr1); end
    cycle(1'b0, 1'b0, 0, 0);
    cycle(1'b0, 1'b1, 8, 12);
    checks++;
    if (addr1 !== 17'd1924) begin errors++; $display("FAIL midframe_next_2x act=%0d req=1924", addr1); end
    checks++;
    if (act3_v !== exp3_v) begin errors++; $display("FAIL midframe dut3 act=%h req=%h", act3_v, exp3_v); end
  endtask

  task automatic test_latency_lat3();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 30 + i, 20);
    cycle(1'b0, 1'b1, 20, 20);
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (de_out3 !== (k == 5)) begin errors++; $display("FAIL lat3_de_out k=%0d act=%b req=%b", k, de_out3, (k == 5)); end
      if (k != 5) begin
        checks++;
        if ({r3, g3, b3} !== 12'h000) begin errors++; $display("FAIL lat3_black k=%0d act=%h req=000", k, {r3, g3, b3}); end
      end
      checks++;
      if (act3_v !== exp3_v) begin errors++; $display("FAIL lat3 model k=%0d act=%h req=%h", k, act3_v, exp3_v); end
      cycle(1'b0, 1'b0, 21 + k, 20);
    end
  endtask

  task automatic test_clip();
    logic [16:0] max_a;
    max_a = '0;
    upscale = 1'b0; x_off = 10'd600; y_off = '0;
    cycle(1'b0, 1'b0, 0, 0);
    for (int x = 590; x < 640; x++) begin
      cycle(1'b0, 1'b1, x, 0);
      checks++;
      if (rd_en1 !== (x >= 600)) begin errors++; $display("FAIL clip_rd_en x=%0d act=%b req=%b", x, rd_en1, (x >= 600)); end
      if (rd_en1 === 1'b1 && addr1 > max_a) max_a = addr1;
      checks++;
      if (act1_v !== exp1_v) begin errors++; $display("FAIL clip dut1 x=%0d act=%h req=%h", x, act1_v, exp1_v); end
    end
    checks++;
    if (max_a !== 17'd39) begin errors++; $display("FAIL clip_max_addr act=%0d req=39", max_a); end
  endtask

  task automatic test_random();
    int x, y;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        upscale = 1'($urandom_range(0, 1));
        x_off   = 10'($urandom_range(0, 700));
        y_off   = 10'($urandom_range(0, 500));
      end
      if (n % 250 == 0) begin
        x = 0; y = 0;
      end else begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
      end
      cycle((n % 997 == 500), 1'($urandom_range(0, 3) != 0), x, y);
      checks++;
      if (act1_v !== exp1_v) begin errors++; $display("FAIL random dut1 n=%0d act=%h req=%h", n, act1_v, exp1_v); end
      checks++;
      if (act3_v !== exp3_v) begin errors++; $display("FAIL random dut3 n=%0d act=%h req=%h", n, act3_v, exp3_v); end
    end
  endtask

  task automatic test_back_to_back();
    // a contiguous 2x scan across a window edge, including mid-frame reset
    upscale = 1'b1; x_off = 10'd200; y_off = 10'd100;
    cycle(1'b0, 1'b0, 0, 0);
    for (int y = 99; y < 104; y++) begin
      for (int x = 195; x < 215; x++) begin
        cycle((y == 102 && x == 205), 1'b1, x, y);
        checks++;
        if (act1_v !== exp1_v) begin errors++; $display("FAIL b2b dut1 (%0d,%0d) act=%h req=%h", x, y, act1_v, exp1_v); end
        checks++;
        if (act3_v !== exp3_v) begin errors++; $display("FAIL b2b dut3 (%0d,%0d) act=%h req=%h", x, y, act3_v, exp3_v); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) hist.push_front('0);
    exp_addr = '0; exp_rd = 1'b0;
    m_ups = 1'b0; m_xo = 0; m_yo = 0;
    test_reset();
    test_map_1x();
    test_map_2x();
    test_midframe_config();
    test_latency_lat3();
    test_clip();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
